// File: rtl/bit_serializer.sv
// Parallel-to-serial source for the sequence detector: WIDTH-bit words in over valid/ready,
// one bit per clock out on x, with a one-word hold register so consecutive words stream gap-free.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             xfer;
  logic             last_bit;
  logic [WIDTH-1:0] shift_adv;

  // Ready looks only at registered state so it can never loop back through din_valid.
  assign din_ready = rst_n && !hold_full_q;
  assign xfer      = din_valid && din_ready;
  assign last_bit  = (state_q == S_SHIFT) && (cnt_q == LAST);
  assign shift_adv = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  assign x_valid   = (state_q == S_SHIFT);
  assign x         = x_valid ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]) : IDLE_LEVEL;
  assign word_done = last_bit;
  assign busy      = (state_q == S_SHIFT) || hold_full_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          shift_d = din;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == LAST) begin
          // A held word wins the reload; ready is already low then, so xfer cannot collide.
          cnt_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_d      = '0;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            shift_d = din;
          end else begin
            shift_d = '0;
            state_d = S_IDLE;
          end
        end else begin
          shift_d = shift_adv;
          cnt_d   = cnt_q + CW'(1);
          if (xfer) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
